// File: rtl/ppu_pkg.sv
// Shared PPU types: copier FSM state and write-latency helper.
package ppu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } isc_state_t;

  // Issue-to-write latency: address-buffer read followed by source read.
  function automatic int unsigned isc_wr_lat(input int unsigned abuf_lat,
                                             input int unsigned src_lat);
    return abuf_lat + src_lat;
  endfunction

endpackage

// File: rtl/delay_line.sv
// Fixed-depth register pipeline, cleared by asynchronous reset.
module delay_line #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [WIDTH-1:0] stage_d [DEPTH];

  always_comb begin
    stage_d[0] = din;
    for (int unsigned k = 1; k < DEPTH; k++) begin
      stage_d[k] = stage_q[k-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        stage_q[k] <= '0;
      end
    end else begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        stage_q[k] <= stage_d[k];
      end
    end
  end

  assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/up_counter.sv
// Loadable up counter; load takes priority over increment.
module up_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             inc,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (inc) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q = cnt_q;

endmodule

// File: rtl/indirect_sync_copier.sv
// On sync, walks the address buffer, reads the source RAM through each entry
// and writes the results contiguously into the target RAM from targ_base.
module indirect_sync_copier
  import ppu_pkg::*;
#(
  parameter int unsigned ABUF_ADDR_WIDTH = 6,
  parameter int unsigned SRC_ADDR_WIDTH  = 12,
  parameter int unsigned TARG_ADDR_WIDTH = 6,
  parameter int unsigned DATA_WIDTH      = 64,
  parameter int unsigned ABUF_RD_LAT     = 2,
  parameter int unsigned SRC_RD_LAT      = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sync,
  input  logic [ABUF_ADDR_WIDTH:0]   count,
  input  logic [TARG_ADDR_WIDTH-1:0] targ_base,
  output logic                       busy,
  output logic                       done,
  output logic [ABUF_ADDR_WIDTH-1:0] addr_abuf,
  input  logic [SRC_ADDR_WIDTH:0]    rddata_abuf,
  output logic [SRC_ADDR_WIDTH-1:0]  addr_src,
  output logic                       wren_src,
  input  logic [DATA_WIDTH-1:0]      rddata_src,
  output logic [TARG_ADDR_WIDTH-1:0] addr_targ,
  output logic [DATA_WIDTH-1:0]      wrdata_targ,
  output logic                       wren_targ
);

  localparam int unsigned WR_LAT = isc_wr_lat(ABUF_RD_LAT, SRC_RD_LAT);
  localparam int unsigned CW     = ABUF_ADDR_WIDTH + 1;
  localparam logic [CW-1:0] MAX_CNT = {1'b1, {ABUF_ADDR_WIDTH{1'b0}}};

  isc_state_t state_q, state_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] rem_q, rem_d;

  logic                       accept;
  logic                       issue;
  logic                       last_issue;
  logic                       idx_inc;
  logic [CW-1:0]              sat_count;
  logic [ABUF_ADDR_WIDTH-1:0] idx;
  logic                       tok_out;
  logic                       en_dly;

  // rem counts writes still owed; done fires on the cycle after the last one.
  always_comb begin
    sat_count  = (count > MAX_CNT) ? MAX_CNT : count;
    accept     = (state_q == IDLE) && sync;
    issue      = (state_q == ISSUE);
    last_issue = issue && ({1'b0, idx} == (cnt_q - CW'(1)));
    idx_inc    = issue && !last_issue;

    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    done_d  = 1'b0;

    if (tok_out) begin
      rem_d = rem_q - CW'(1);
    end

    case (state_q)
      IDLE: begin
        if (sync) begin
          cnt_d   = sat_count;
          rem_d   = sat_count;
          state_d = (sat_count == '0) ? DRAIN : ISSUE;
        end
      end
      ISSUE: begin
        if (last_issue) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if ((rem_q == '0) || ((rem_q == CW'(1)) && tok_out)) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
    end
  end

  up_counter #(
    .WIDTH(ABUF_ADDR_WIDTH)
  ) u_idx_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .load_val ('0),
    .inc      (idx_inc),
    .q        (idx)
  );

  up_counter #(
    .WIDTH(TARG_ADDR_WIDTH)
  ) u_wr_addr_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .load_val (targ_base),
    .inc      (tok_out),
    .q        (addr_targ)
  );

  // One token per issued index, emerging exactly when its source data is valid.
  delay_line #(
    .WIDTH(1),
    .DEPTH(WR_LAT)
  ) u_tok_dly (
    .clk  (clk),
    .rst  (rst),
    .din  (issue),
    .dout (tok_out)
  );

  delay_line #(
    .WIDTH(1),
    .DEPTH(SRC_RD_LAT)
  ) u_en_dly (
    .clk  (clk),
    .rst  (rst),
    .din  (rddata_abuf[SRC_ADDR_WIDTH]),
    .dout (en_dly)
  );

  assign addr_abuf   = idx;
  assign addr_src    = rddata_abuf[SRC_ADDR_WIDTH-1:0];
  assign wren_src    = 1'b0;
  assign wren_targ   = tok_out;
  assign wrdata_targ = en_dly ? rddata_src : '0;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_indirect_sync_copier.sv
// Directed bench: two copiers (2+2 and 1+3 read latencies, both L=4) share
// stimulus and address-buffer contents, each with its own RAM latency models.
module tb_indirect_sync_copier;

  localparam int AW = 6;
  localparam int SW = 12;
  localparam int TW = 6;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          sync;
  logic [AW:0]   count;
  logic [TW-1:0] targ_base;

  wire [1:0]          busy_o, done_o, wren_o, wsrc_o;
  wire [1:0][AW-1:0]  aab_o;
  wire [1:0][SW-1:0]  asrc_o;
  wire [1:0][TW-1:0]  at_o;
  wire [1:0][DW-1:0]  wd_o;
  wire [1:0][SW:0]    rd_abuf;
  wire [1:0][DW-1:0]  rd_src;

  logic [SW:0]   abuf_mem [64];
  logic [SW:0]   ab0_p1, ab0_p2, ab1_p1;
  logic [DW-1:0] s0_p1, s0_p2, s1_p1, s1_p2, s1_p3;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [AW:0]   cnt;
    logic [TW-1:0] base;
    logic [63:0]   dis;
    int            exp_done;
    int            exp_nwr;
  } vec_t;

  vec_t vecs[5];

  always #5 clk = ~clk;

  indirect_sync_copier u_dut0 (
    .clk(clk), .rst(rst), .sync(sync), .count(count), .targ_base(targ_base),
    .busy(busy_o[0]), .done(done_o[0]), .addr_abuf(aab_o[0]),
    .rddata_abuf(rd_abuf[0]), .addr_src(asrc_o[0]), .wren_src(wsrc_o[0]),
    .rddata_src(rd_src[0]), .addr_targ(at_o[0]), .wrdata_targ(wd_o[0]),
    .wren_targ(wren_o[0])
  );

  indirect_sync_copier #(.ABUF_RD_LAT(1), .SRC_RD_LAT(3)) u_dut1 (
    .clk(clk), .rst(rst), .sync(sync), .count(count), .targ_base(targ_base),
    .busy(busy_o[1]), .done(done_o[1]), .addr_abuf(aab_o[1]),
    .rddata_abuf(rd_abuf[1]), .addr_src(asrc_o[1]), .wren_src(wsrc_o[1]),
    .rddata_src(rd_src[1]), .addr_targ(at_o[1]), .wrdata_targ(wd_o[1]),
    .wren_targ(wren_o[1])
  );

  function automatic logic [DW-1:0] src_word(input logic [SW-1:0] a);
    return DW'(a) + DW'(100);
  endfunction

  always @(posedge clk) begin
    ab0_p1 <= abuf_mem[aab_o[0]];
    ab0_p2 <= ab0_p1;
    s0_p1  <= src_word(asrc_o[0]);
    s0_p2  <= s0_p1;
    ab1_p1 <= abuf_mem[aab_o[1]];
    s1_p1  <= src_word(asrc_o[1]);
    s1_p2  <= s1_p1;
    s1_p3  <= s1_p2;
  end

  assign rd_abuf = {ab1_p1, ab0_p2};
  assign rd_src  = {s1_p3, s0_p2};

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic fill_abuf(input logic [63:0] dis);
    for (int i = 0; i < 64; i++) begin
      abuf_mem[i] = {~dis[i], SW'(3 * i)};
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("%s_d%0d_busy", tag, d), 64'(busy_o[d]), 64'd0);
      check($sformatf("%s_d%0d_done", tag, d), 64'(done_o[d]), 64'd0);
      check($sformatf("%s_d%0d_wren", tag, d), 64'(wren_o[d]), 64'd0);
      check($sformatf("%s_d%0d_addr_abuf", tag, d), 64'(aab_o[d]), 64'd0);
      check($sformatf("%s_d%0d_addr_targ", tag, d), 64'(at_o[d]), 64'd0);
      check($sformatf("%s_d%0d_wrdata", tag, d), wd_o[d], 64'd0);
      check($sformatf("%s_d%0d_wren_src", tag, d), 64'(wsrc_o[d]), 64'd0);
    end
  endtask

  // Pulse sync for one edge; count/targ_base are then scrambled to show they are latched.
  task automatic start(input logic [AW:0] c, input logic [TW-1:0] b);
    @(negedge clk);
    sync = 1'b1;
    count = c;
    targ_base = b;
    @(posedge clk);
    #1;
    sync = 1'b0;
    count = 7'h7f;
    targ_base = 6'h2a;
  endtask

  task automatic run_vec(input int vi, input vec_t v);
    int nw[2];
    logic [TW-1:0] ea;
    logic [DW-1:0] ed;
    nw = '{0, 0};
    fill_abuf(v.dis);
    start(v.cnt, v.base);
    for (int c = 0; c <= v.exp_done + 3; c++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (c < v.exp_nwr)
          check($sformatf("v%0d_d%0d_c%0d_addr_abuf", vi, d, c), 64'(aab_o[d]), 64'(c));
        check($sformatf("v%0d_d%0d_c%0d_busy", vi, d, c), 64'(busy_o[d]), 64'(c < v.exp_done));
        check($sformatf("v%0d_d%0d_c%0d_done", vi, d, c), 64'(done_o[d]), 64'(c == v.exp_done));
        if (wren_o[d] === 1'b1) begin
          ea = v.base + TW'(nw[d]);
          ed = v.dis[nw[d] & 63] ? 64'd0 : 64'(3 * (nw[d] & 63) + 100);
          check($sformatf("v%0d_d%0d_w%0d_cycle", vi, d, nw[d]), 64'(c), 64'(4 + nw[d]));
          check($sformatf("v%0d_d%0d_w%0d_addr", vi, d, nw[d]), 64'(at_o[d]), 64'(ea));
          check($sformatf("v%0d_d%0d_w%0d_data", vi, d, nw[d]), wd_o[d], ed);
          nw[d]++;
        end
      end
    end
    for (int d = 0; d < 2; d++)
      check($sformatf("v%0d_d%0d_nwrites", vi, d), 64'(nw[d]), 64'(v.exp_nwr));
  endtask

  initial begin
    int ndone[2];
    int dcyc[2][3];
    int nwr[2];

    vecs[0] = '{7'd41,  6'd0,  64'd0,                  45, 41};
    vecs[1] = '{7'd5,   6'd0,  64'b01010,              9,  5};
    vecs[2] = '{7'd4,   6'd62, 64'd0,                  8,  4};
    vecs[3] = '{7'd0,   6'd5,  64'd0,                  1,  0};
    vecs[4] = '{7'd100, 6'd10, 64'h8000_0000_0000_0001, 68, 64};

    rst = 1'b1;
    sync = 1'b0;
    count = '0;
    targ_base = '0;
    fill_abuf(64'd0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("in_reset");
    rst = 1'b0;
    @(negedge clk);
    check_outputs_zero("after_reset");

    for (int i = 0; i < 5; i++) run_vec(i, vecs[i]);

    // sync pulsed while busy must be ignored
    fill_abuf(64'd0);
    ndone = '{0, 0};
    start(7'd5, 6'd0);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      sync = (c == 2);
      for (int d = 0; d < 2; d++) begin
        if (done_o[d] === 1'b1) begin
          check($sformatf("busy_sync_d%0d_done_cycle", d), 64'(c), 64'd9);
          ndone[d]++;
        end
      end
    end
    for (int d = 0; d < 2; d++)
      check($sformatf("busy_sync_d%0d_ndone", d), 64'(ndone[d]), 64'd1);

    // sync held high: back-to-back runs separated by the single done/IDLE cycle
    ndone = '{0, 0};
    @(negedge clk);
    sync = 1'b1;
    count = 7'd2;
    targ_base = 6'd0;
    @(posedge clk);
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (c == 6 || c == 7)
          check($sformatf("held_d%0d_c%0d_busy", d, c), 64'(busy_o[d]), 64'(c == 7));
        if (done_o[d] === 1'b1) begin
          if (ndone[d] < 3) dcyc[d][ndone[d]] = c;
          ndone[d]++;
        end
      end
      if (c == 13) sync = 1'b0;
    end
    for (int d = 0; d < 2; d++) begin
      check($sformatf("held_d%0d_ndone", d), 64'(ndone[d]), 64'd2);
      if (ndone[d] >= 2) begin
        check($sformatf("held_d%0d_done0", d), 64'(dcyc[d][0]), 64'd6);
        check($sformatf("held_d%0d_done1", d), 64'(dcyc[d][1]), 64'd13);
      end
    end

    // reset during write 10 of 41 aborts the run cleanly
    fill_abuf(64'd0);
    start(7'd41, 6'd0);
    for (int c = 0; c < 14; c++) @(negedge clk);
    for (int d = 0; d < 2; d++)
      check($sformatf("abort_d%0d_wren_before", d), 64'(wren_o[d]), 64'd1);
    rst = 1'b1;
    #1;
    check_outputs_zero("abort_now");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    nwr = '{0, 0};
    ndone = '{0, 0};
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (wren_o[d] === 1'b1) nwr[d]++;
        if (done_o[d] === 1'b1) ndone[d]++;
      end
    end
    for (int d = 0; d < 2; d++) begin
      check($sformatf("abort_d%0d_writes_after", d), 64'(nwr[d]), 64'd0);
      check($sformatf("abort_d%0d_done_after", d), 64'(ndone[d]), 64'd0);
      check($sformatf("abort_d%0d_busy_after", d), 64'(busy_o[d]), 64'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1);
  end

endmodule
